// File: rtl/vga_tile_framebuffer.sv
// Tile-grid VGA engine: self-timed raster, GRID_W x GRID_H colour map, optional grid-line overlay, clear FSM.
// Latency: beam counter to pins is 3 clocks (address, RAM read, output mux); syncs/blank/frame-start delayed to match.
// Backpressure: display never stalls; tile writes see oWR_READY low while the clear FSM owns the RAM write port.
module vga_tile_framebuffer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int BLOCK_LOG2 = 5,
    parameter int GRID_W     = 20,
    parameter int GRID_H     = 15,
    parameter int COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] FILL_COLOR = '0
) (
    input  logic                          iVGA_CLK,
    input  logic                          iRST,
    input  logic                          iWR_VALID,
    output logic                          oWR_READY,
    input  logic [$clog2(GRID_W)-1:0]     iWR_X,
    input  logic [$clog2(GRID_H)-1:0]     iWR_Y,
    input  logic [COLOR_W-1:0]            iWR_DATA,
    output logic                          oWR_ERR,
    input  logic                          iCLR_REQ,
    input  logic [COLOR_W-1:0]            iCLR_DATA,
    output logic                          oCLR_BUSY,
    input  logic                          iGRIDLINE_EN,
    input  logic [COLOR_W-1:0]            iGRIDLINE_COLOR,
    output logic                          oHS,
    output logic                          oVS,
    output logic                          oBLANK_n,
    output logic [COLOR_W/3-1:0]          oVGA_R,
    output logic [COLOR_W/3-1:0]          oVGA_G,
    output logic [COLOR_W/3-1:0]          oVGA_B,
    output logic                          oFRAME_START
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int N       = GRID_W * GRID_H;
    localparam int AW      = $clog2(N);
    localparam int CW      = COLOR_W / 3;

    // Per-pixel control that travels alongside the colour through the pipe
    typedef struct packed {
        logic act;
        logic in_grid;
        logic grid;
        logic hs;
        logic vs;
        logic fs;
    } beam_t;

    localparam beam_t BEAM_RST = '{act: 1'b0, in_grid: 1'b0, grid: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    logic [HW-1:0]      h_q;
    logic [VW-1:0]      v_q;
    logic [31:0]        h32, v32;
    beam_t              beam_d, s1_q, s2_q;
    logic [AW-1:0]      addr_d, addr_q;
    logic [COLOR_W-1:0] mem_q [N];
    logic [COLOR_W-1:0] rdata_q;
    logic               hs_q, vs_q, blank_n_q, fs_q;
    logic [COLOR_W-1:0] rgb_q;

    state_t             state_q;
    logic [AW-1:0]      clr_addr_q;
    logic [COLOR_W-1:0] clr_data_q;
    logic               wr_err_q;
    logic               wr_fire, wr_in_range;
    logic [AW-1:0]      wr_addr;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [COLOR_W-1:0] mem_wdata;

    // Beam counters: h wraps at H_TOTAL and carries into v
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == HW'(H_TOTAL - 1)) begin
            h_q <= '0;
            v_q <= (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end else begin
            h_q <= h_q + HW'(1);
        end
    end

    // Stage 1 decode: tile address, active/grid region, syncs, overlay hit
    always_comb begin
        h32            = 32'(h_q);
        v32            = 32'(v_q);
        beam_d.act     = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        beam_d.in_grid = (h32 < (GRID_W << BLOCK_LOG2)) && (v32 < (GRID_H << BLOCK_LOG2));
        beam_d.grid    = iGRIDLINE_EN && ((h_q[BLOCK_LOG2-1:0] == '0) || (v_q[BLOCK_LOG2-1:0] == '0));
        beam_d.hs      = !((h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC));
        beam_d.vs      = !((v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC));
        beam_d.fs      = (h_q == '0) && (v_q == '0);
        // Off-grid pixels are masked later, so park their read on a legal address
        addr_d         = beam_d.in_grid ? AW'((v32 >> BLOCK_LOG2) * GRID_W + (h32 >> BLOCK_LOG2)) : '0;
    end

    // Stage 1/2 pipeline registers, flushed to a blank pixel on reset
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            s1_q   <= BEAM_RST;
            s2_q   <= BEAM_RST;
            addr_q <= '0;
        end else begin
            s1_q   <= beam_d;
            s2_q   <= s1_q;
            addr_q <= addr_d;
        end
    end

    // Tile RAM: one write port, registered read; a colliding read sees the old word
    always_ff @(posedge iVGA_CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        rdata_q <= mem_q[addr_q];
    end

    // Stage 3: colour priority mux and output registers
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            fs_q      <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hs_q      <= s2_q.hs;
            vs_q      <= s2_q.vs;
            blank_n_q <= s2_q.act;
            fs_q      <= s2_q.fs;
            if (!s2_q.act || !s2_q.in_grid) begin
                rgb_q <= '0;
            end else if (s2_q.grid) begin
                rgb_q <= iGRIDLINE_COLOR;
            end else begin
                rgb_q <= rdata_q;
            end
        end
    end

    assign oHS          = hs_q;
    assign oVS          = vs_q;
    assign oBLANK_n     = blank_n_q;
    assign oFRAME_START = fs_q;
    assign oVGA_R       = rgb_q[CW-1:0];
    assign oVGA_G       = rgb_q[2*CW-1:CW];
    assign oVGA_B       = rgb_q[3*CW-1:2*CW];

    assign oWR_READY   = (state_q == ST_IDLE) && !iRST;
    assign oCLR_BUSY   = (state_q == ST_CLEAR);
    assign oWR_ERR     = wr_err_q;
    assign wr_fire     = iWR_VALID && oWR_READY;
    assign wr_in_range = (32'(iWR_X) < GRID_W) && (32'(iWR_Y) < GRID_H);
    assign wr_addr     = AW'(32'(iWR_Y) * GRID_W + 32'(iWR_X));

    // RAM write arbitration: the clear owns the port while active, else accepted in-range writes
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = iWR_DATA;
        if ((state_q == ST_CLEAR) && !iRST) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = clr_data_q;
        end else if (wr_fire && wr_in_range) begin
            mem_we    = 1'b1;
        end
    end

    // Clear FSM and write-error pulse; reset always (re)starts a fill with FILL_COLOR
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            clr_data_q <= FILL_COLOR;
            wr_err_q   <= 1'b0;
        end else begin
            wr_err_q <= wr_fire && !wr_in_range;
            case (state_q)
                ST_IDLE: begin
                    if (iCLR_REQ) begin
                        clr_data_q <= iCLR_DATA;
                        clr_addr_q <= '0;
                        state_q    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr_q == AW'(N - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        clr_addr_q <= clr_addr_q + AW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
